// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two requesters share a single 16-bit barrel shifter. The arbiter grants one
// requester in IDLE, latches its operands, runs the shifter for one cycle
// (SHIFT) and then presents the result (RESP) until the consumer takes it.
//
// Configuration macro:
//   SHIFT_ARB_RR_EN  defined   -> round-robin arbitration (pointer moves on
//                                 every handshake, favouring the requester
//                                 that was not granted last)
//                    undefined -> fixed priority, requester 0 wins
//
// Ports:
//   clk                    sole clock, rising edge
//   rst                    synchronous active-high reset
//   req0_valid/req0_ready  requester 0 handshake
//   req0_in/cnt/op         requester 0 operand (16), shift count (4), opcode (2)
//   req1_valid/req1_ready  requester 1 handshake
//   req1_in/cnt/op         requester 1 operand (16), shift count (4), opcode (2)
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 requester that issued the response
//   rsp_data               shifted result
//   op_count               completed responses, wraps modulo 256
//
// Opcodes: 00 ROL, 01 SLL, 10 ROR, 11 SRL. A count of 0 passes the operand.
// -----------------------------------------------------------------------------

// Combinational 16-bit shifter. Each output bit is a single indexed select
// of the operand; the logical shifts reuse the rotate select and zero the
// bits that would have wrapped around.
module shift_arbiter_shifter (
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic [15:0] Out
);

  logic [15:0] rol_bits;
  logic [15:0] ror_bits;
  logic [15:0] sll_bits;
  logic [15:0] srl_bits;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
      localparam logic [3:0] POS = 4'(gi);
      // 4-bit index arithmetic wraps modulo 16, which is exactly a rotate.
      assign rol_bits[gi] = In[POS - Cnt];
      assign ror_bits[gi] = In[POS + Cnt];
      // Left shift: bit is valid only if its source did not come from above bit 15.
      assign sll_bits[gi] = (Cnt <= POS) ? rol_bits[gi] : 1'b0;
      // Right shift: bit is valid only if its source lies at or below bit 15.
      assign srl_bits[gi] = (({1'b0, POS} + {1'b0, Cnt}) <= 5'd15) ? ror_bits[gi] : 1'b0;
    end
  endgenerate

  always_comb begin
    Out = In;
    case (Op)
      2'b00:   Out = rol_bits;
      2'b01:   Out = sll_bits;
      2'b10:   Out = ror_bits;
      default: Out = srl_bits;
    endcase
  end

endmodule

module shift_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_cnt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_cnt,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] in_reg;
  logic [3:0]  cnt_reg;
  logic [1:0]  op_reg;
  logic        gnt_id_reg;
  logic        rsp_valid_reg;
  logic        rsp_id_reg;
  logic [15:0] rsp_data_reg;
  logic [7:0]  op_count_reg;
  logic [15:0] shift_out;

  logic grant0;
  logic grant1;

`ifdef SHIFT_ARB_RR_EN
  // 1 means requester 1 currently has priority.
  logic prio_reg;

  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~prio_reg);
    grant1 = req1_valid & (~req0_valid |  prio_reg);
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  // Ready never looks at rsp_ready, so no combinational path runs from the
  // consumer back to the requesters.
  assign req0_ready = ~rst & (state_reg == IDLE) & grant0;
  assign req1_ready = ~rst & (state_reg == IDLE) & grant1;

  // The shifter is only meaningful in SHIFT; it always sees the latched
  // operands so its inputs are stable for that whole cycle.
  shift_arbiter_shifter u_shifter (
    .In  (in_reg),
    .Cnt (cnt_reg),
    .Op  (op_reg),
    .Out (shift_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_reg        <= 16'h0000;
      cnt_reg       <= 4'h0;
      op_reg        <= 2'b00;
      gnt_id_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= 16'h0000;
      op_count_reg  <= 8'h00;
`ifdef SHIFT_ARB_RR_EN
      prio_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_ready) begin
            in_reg     <= req0_in;
            cnt_reg    <= req0_cnt;
            op_reg     <= req0_op;
            gnt_id_reg <= 1'b0;
            state_reg  <= SHIFT;
`ifdef SHIFT_ARB_RR_EN
            prio_reg   <= 1'b1;
`endif
          end else if (req1_ready) begin
            in_reg     <= req1_in;
            cnt_reg    <= req1_cnt;
            op_reg     <= req1_op;
            gnt_id_reg <= 1'b1;
            state_reg  <= SHIFT;
`ifdef SHIFT_ARB_RR_EN
            prio_reg   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          rsp_data_reg  <= shift_out;
          rsp_id_reg    <= gnt_id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          // Response data and id stay frozen here until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + 8'd1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Directed bench for shift_arbiter. Inputs change 1 time unit after a rising
// edge and outputs are sampled there too, well away from the next edge.
// Expected values are hand-computed constants; op_count is tracked locally.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_in;
  logic [3:0]  req0_cnt;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_in;
  logic [3:0]  req1_cnt;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic [7:0]  op_count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  exp_count  = 8'h00;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_cnt   (req0_cnt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_cnt   (req1_cnt),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .op_count   (op_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE with an immediate consumer.
  task automatic run_op(input logic id, input logic [15:0] din, input logic [3:0] c,
                        input logic [1:0] o, input logic [15:0] exp);
    if (id) begin
      req1_in = din; req1_cnt = c; req1_op = o; req1_valid = 1'b1;
    end else begin
      req0_in = din; req0_cnt = c; req0_op = o; req0_valid = 1'b1;
    end
    #1;
    check("op_ready0", req0_ready, !id);
    check("op_ready1", req1_ready, id);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("op_shift_valid", rsp_valid, 0);
    tick;
    check("op_rsp_valid", rsp_valid, 1);
    check("op_rsp_id", rsp_id, id);
    check("op_rsp_data", rsp_data, exp);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    check("op_idle_valid", rsp_valid, 0);
    check("op_count", op_count, exp_count);
    $display("op id=%0d in=0x%04h cnt=%0d op=%0d -> data=0x%04h count=%0d",
             id, din, c, o, exp, exp_count);
  endtask

  initial begin
    logic exp_id;

    rst = 1'b1;
    req0_valid = 1'b1; req0_in = 16'h0; req0_cnt = 4'h0; req0_op = 2'b00;
    req1_valid = 1'b1; req1_in = 16'h0; req1_cnt = 4'h0; req1_op = 2'b00;
    rsp_ready  = 1'b0;

    // Reset state, readies held low while rst is high.
    tick;
    tick;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_op_count", op_count, 8'h00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick;

    // ROL 0x8001 by 1, then a 5-cycle response stall.
    req0_in = 16'h8001; req0_cnt = 4'd1; req0_op = 2'b00; req0_valid = 1'b1;
    #1;
    check("first_ready0", req0_ready, 1);
    check("first_ready1", req1_ready, 0);
    tick;
    check("first_shift_ready0", req0_ready, 0);
    check("first_shift_valid", rsp_valid, 0);
    req0_valid = 1'b0;
    tick;
    check("first_rsp_valid", rsp_valid, 1);
    check("first_rsp_data", rsp_data, 16'h0003);
    check("first_rsp_id", rsp_id, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, 16'h0003);
      check("hold_rsp_id", rsp_id, 0);
      check("hold_op_count", op_count, 8'h00);
      $display("hold cycle %0d rsp_valid=%0d rsp_data=0x%04h", i, rsp_valid, rsp_data);
      tick;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick;
    rsp_ready  = 1'b0;
    exp_count  = 8'd1;
    check("hold_release_valid", rsp_valid, 0);
    check("hold_release_count", op_count, exp_count);

    // Single-requester vectors for every opcode; last one is requester 1.
    run_op(1'b0, 16'h0001, 4'd15, 2'b01, 16'h8000);
    run_op(1'b0, 16'h1234, 4'd4,  2'b00, 16'h2341);
    run_op(1'b0, 16'hFFFF, 4'd8,  2'b01, 16'hFF00);
    run_op(1'b0, 16'h8001, 4'd0,  2'b00, 16'h8001);
    run_op(1'b1, 16'h1234, 4'd4,  2'b10, 16'h4123);
    run_op(1'b1, 16'hF000, 4'd0,  2'b11, 16'hF000);
    run_op(1'b1, 16'h8000, 4'd15, 2'b11, 16'h0001);
    run_op(1'b1, 16'h00F0, 4'd4,  2'b10, 16'h000F);
    run_op(1'b1, 16'h1234, 4'd0,  2'b01, 16'h1234);

    // Both requesters valid continuously for four grants.
    req0_in = 16'h0001; req0_cnt = 4'd1; req0_op = 2'b01;
    req1_in = 16'h0100; req1_cnt = 4'd1; req1_op = 2'b11;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
      exp_id = (i % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      #1;
      check("arb_ready0", req0_ready, !exp_id);
      check("arb_ready1", req1_ready, exp_id);
      tick;
      check("arb_shift_ready0", req0_ready, 0);
      check("arb_shift_ready1", req1_ready, 0);
      tick;
      check("arb_rsp_id", rsp_id, exp_id);
      check("arb_rsp_data", rsp_data, exp_id ? 16'h0080 : 16'h0002);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      exp_count = exp_count + 8'd1;
      check("arb_op_count", op_count, exp_count);
      $display("contention grant %0d -> id=%0d data=0x%04h", i, rsp_id, rsp_data);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset while in SHIFT aborts the operation.
    req0_in = 16'h0001; req0_cnt = 4'd1; req0_op = 2'b01; req0_valid = 1'b1;
    #1;
    check("abort_shift_grant", req0_ready, 1);
    tick;
    req0_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_count = 8'h00;
    check("abort_shift_valid", rsp_valid, 0);
    check("abort_shift_count", op_count, exp_count);
    tick;
    check("abort_shift_no_rsp", rsp_valid, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("abort_idle_ready0", req0_ready, 1);
    check("abort_idle_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("reset during SHIFT: rsp_valid=%0d op_count=%0d", rsp_valid, op_count);
    tick;

    // Reset while in RESP drops the response without counting it.
    req1_in = 16'h0003; req1_cnt = 4'd1; req1_op = 2'b01; req1_valid = 1'b1;
    #1;
    tick;
    req1_valid = 1'b0;
    tick;
    check("abort_resp_valid_before", rsp_valid, 1);
    check("abort_resp_data_before", rsp_data, 16'h0006);
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_resp_valid", rsp_valid, 0);
    check("abort_resp_count", op_count, 8'h00);
    $display("reset during RESP: rsp_valid=%0d op_count=%0d", rsp_valid, op_count);

    // 256 completions from reset wrap op_count back to zero.
    for (int i = 0; i < 256; i++) begin
      run_op(1'b0, 16'(i * 257), 4'd0, 2'b01, 16'(i * 257));
      if (i == 254) check("wrap_count_ff", op_count, 8'hFF);
    end
    check("wrap_count_00", op_count, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
